alu_unit: RTL and testbench
===========================

# alu_unit

Integer execute unit behind the reservation station. It takes one issued instruction per cycle (op, immediate, PC, ROB tag, both operand values) and computes the RV32I result and, for control-flow ops, the resolved branch outcome. It broadcasts the result one cycle later on the ALU result bus, which feeds the reservation station, load/store buffer and ROB wake-up logic. The output stage is registered, stalls with the global `ready`, and is cleared by pipeline flush.

## Interface
Parameters (all from the shared definitions header):
- `DATA_W`, 32, operand/result width
- `ADDR_W`, 32, PC width
- `IMM_W`, 32, immediate width (already sign-extended; LUI/AUIPC immediates pre-shifted)
- `ROB_W`, 4, ROB tag width
- `OP_W`, 6, internal opcode width

Ports:
- `clk` in 1: clock
- `reset` in 1: asynchronous, active-high
- `ready` in 1: global run enable; low = freeze all state
- `flush` in 1: misprediction rollback; kill in-flight work
- `in_flag` in 1: issue valid (reservation station front)
- `in_op` in OP_W: internal opcode
- `in_imm` in IMM_W: immediate
- `in_pc` in ADDR_W: instruction PC
- `in_robpos` in ROB_W: destination ROB tag
- `in_vj` in DATA_W: rs1 value
- `in_vk` in DATA_W: rs2 value
- `out_flag` out 1: result valid
- `out_val` out DATA_W: result value
- `out_robpos` out ROB_W: ROB tag of result
- `out_jump` out 1: control transfer taken
- `out_target` out ADDR_W: next PC of the instruction

## Operation
- No backpressure: every `in_flag` accepted while `ready`=1 is executed.
- Result rules (32-bit wrap arithmetic, shifts use low 5 bits of shamt source):
  - LUI: val=imm. AUIPC: val=pc+imm.
  - JAL: val=pc+4, jump=1, target=pc+imm. JALR: val=pc+4, jump=1, target=(vj+imm)&~1.
  - BEQ/BNE/BLT/BGE (signed)/BLTU/BGEU (unsigned) compare vj,vk: val=0, jump=cond, target=cond ? pc+imm : pc+4.
  - ADDI/SLTI/SLTIU/XORI/ORI/ANDI/SLLI/SRLI/SRAI: vj op imm. SLTIU compares imm as unsigned after sign extension.
  - ADD/SUB/SLL/SLT/SLTU/XOR/OR/AND/SRL/SRA: vj op vk. SLT/SLTU produce 0 or 1.
  - Non-control ops: jump=0, target=pc+4.
  - Unknown op: val=0, jump=0, target=pc+4, out_flag still asserted (ROB must not hang).
- Priority at a posedge when `ready`=1: flush > issue > idle.
  - flush=1: out_flag<=0, input discarded even if in_flag=1.
  - else in_flag=1: load all outputs, out_flag<=1.
  - else out_flag<=0. Data outputs keep their old values (don't-care).
- `ready`=0: all output registers hold, including out_flag. Consumers are gated by the same `ready`, so the broadcast is not double-counted.

## Timing
- Reset (async, immediate): out_flag=0, out_val=0, out_robpos=0, out_jump=0, out_target=0.
- Latency 1: issue sampled at edge N, result visible after edge N; out_flag is a one-cycle pulse per issue when `ready` stays high.
- Back-to-back issues give back-to-back pulses, 1 result/cycle.
- Flush and issue in the same cycle: issue is lost, no pulse. A result already on the outputs from the previous edge is not retracted, but it is cleared at the flush edge.
- Reset asserted mid-operation clears the pending pulse immediately. The first issue after release behaves normally.

## Structure
- Shared definitions header: width constants and the internal opcode enumeration, shared with the decoder and reservation station.
- Sub-module `alu_core`: purely combinational, (op, imm, pc, vj, vk) -> (val, jump, target).
- `alu_unit`: input qualification, flush/ready priority, output registers.

## Test plan
- Reset: assert reset with in_flag=1 -> all outputs 0 asynchronously. After release with no issue, out_flag stays 0.
- Arithmetic: ADD vj=0xFFFFFFFF vk=1 -> out_val=0 next cycle, out_flag=1 for exactly one cycle. SUB 0,1 -> 0xFFFFFFFF. SRA 0x80000000 by 31 (vk=0x3F) -> 0xFFFFFFFF. SLTU 1,0xFFFFFFFF -> 1. SLT same operands -> 0.
- Branches: pc=0x100, imm=0x20. BLT vj=-1 vk=0 -> jump=1, target=0x120, val=0. BLTU with the same operands -> jump=0, target=0x104. JALR vj=0x203 imm=0 -> target=0x202, val=0x104.
- Stall: issue ADDI robpos=5, then drop ready for 3 cycles -> out_flag=1, out_robpos=5 held all 3 cycles. Raise ready with no issue -> out_flag=0 after the next edge.
- Flush: in_flag=1 and flush=1 at the same edge -> out_flag=0. Previous-cycle result pulse is cleared at that edge. The next issue after flush completes normally.
- Throughput: 4 consecutive issues with robpos 0–3 -> 4 consecutive out_flag pulses carrying tags 0,1,2,3 in order, each with the correct value.

Source files
------------

// File: rtl/alu_unit_pkg.sv
// Shared widths and internal opcode encoding used by the decoder, reservation station and ALU.
package alu_unit_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;
  localparam int IMM_W  = 32;
  localparam int ROB_W  = 4;
  localparam int OP_W   = 6;

  // Code 0 and anything past OP_SRA are not valid instructions.
  typedef enum logic [OP_W-1:0] {
    OP_NONE  = 6'd0,
    OP_LUI   = 6'd1,
    OP_AUIPC = 6'd2,
    OP_JAL   = 6'd3,
    OP_JALR  = 6'd4,
    OP_BEQ   = 6'd5,
    OP_BNE   = 6'd6,
    OP_BLT   = 6'd7,
    OP_BGE   = 6'd8,
    OP_BLTU  = 6'd9,
    OP_BGEU  = 6'd10,
    OP_ADDI  = 6'd11,
    OP_SLTI  = 6'd12,
    OP_SLTIU = 6'd13,
    OP_XORI  = 6'd14,
    OP_ORI   = 6'd15,
    OP_ANDI  = 6'd16,
    OP_SLLI  = 6'd17,
    OP_SRLI  = 6'd18,
    OP_SRAI  = 6'd19,
    OP_ADD   = 6'd20,
    OP_SUB   = 6'd21,
    OP_SLL   = 6'd22,
    OP_SLT   = 6'd23,
    OP_SLTU  = 6'd24,
    OP_XOR   = 6'd25,
    OP_OR    = 6'd26,
    OP_AND   = 6'd27,
    OP_SRL   = 6'd28,
    OP_SRA   = 6'd29
  } alu_op_e;

  function automatic logic [DATA_W-1:0] flag_to_word(input logic b);
    return {{(DATA_W-1){1'b0}}, b};
  endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational RV32I datapath: computes result, branch decision and next PC for one instruction.
module alu_core
  import alu_unit_pkg::*;
(
  input  logic [OP_W-1:0]   op,
  input  logic [IMM_W-1:0]  imm,
  input  logic [ADDR_W-1:0] pc,
  input  logic [DATA_W-1:0] vj,
  input  logic [DATA_W-1:0] vk,
  output logic [DATA_W-1:0] val,
  output logic              jump,
  output logic [ADDR_W-1:0] target
);

  logic [ADDR_W-1:0] pc_plus4;
  logic [ADDR_W-1:0] pc_plus_imm;
  logic [DATA_W-1:0] vj_plus_imm;
  logic              take;

  assign pc_plus4    = pc + ADDR_W'(4);
  assign pc_plus_imm = pc + imm;
  assign vj_plus_imm = vj + imm;

  always_comb begin
    take = 1'b0;
    case (op)
      OP_BEQ:  take = (vj == vk);
      OP_BNE:  take = (vj != vk);
      OP_BLT:  take = ($signed(vj) <  $signed(vk));
      OP_BGE:  take = ($signed(vj) >= $signed(vk));
      OP_BLTU: take = (vj <  vk);
      OP_BGEU: take = (vj >= vk);
      default: take = 1'b0;
    endcase
  end

  // Unknown opcodes fall through to the defaults so the ROB still sees a completion.
  always_comb begin
    val    = '0;
    jump   = 1'b0;
    target = pc_plus4;
    case (op)
      OP_LUI:   val = imm;
      OP_AUIPC: val = pc_plus_imm;
      OP_JAL: begin
        val    = pc_plus4;
        jump   = 1'b1;
        target = pc_plus_imm;
      end
      OP_JALR: begin
        val    = pc_plus4;
        jump   = 1'b1;
        target = {vj_plus_imm[ADDR_W-1:1], 1'b0};
      end
      OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU: begin
        jump   = take;
        target = take ? pc_plus_imm : pc_plus4;
      end
      OP_ADDI:  val = vj_plus_imm;
      OP_SLTI:  val = flag_to_word($signed(vj) < $signed(imm));
      OP_SLTIU: val = flag_to_word(vj < imm);
      OP_XORI:  val = vj ^ imm;
      OP_ORI:   val = vj | imm;
      OP_ANDI:  val = vj & imm;
      OP_SLLI:  val = vj << imm[4:0];
      OP_SRLI:  val = vj >> imm[4:0];
      OP_SRAI:  val = $signed(vj) >>> imm[4:0];
      OP_ADD:   val = vj + vk;
      OP_SUB:   val = vj - vk;
      OP_SLL:   val = vj << vk[4:0];
      OP_SLT:   val = flag_to_word($signed(vj) < $signed(vk));
      OP_SLTU:  val = flag_to_word(vj < vk);
      OP_XOR:   val = vj ^ vk;
      OP_OR:    val = vj | vk;
      OP_AND:   val = vj & vk;
      OP_SRL:   val = vj >> vk[4:0];
      OP_SRA:   val = $signed(vj) >>> vk[4:0];
      default: begin
        val    = '0;
        jump   = 1'b0;
        target = pc_plus4;
      end
    endcase
  end

endmodule

// File: rtl/alu_unit.sv
// Integer execute unit: one issue per cycle, result broadcast one cycle later on the ALU bus.
module alu_unit
  import alu_unit_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              ready,
  input  logic              flush,
  input  logic              in_flag,
  input  logic [OP_W-1:0]   in_op,
  input  logic [IMM_W-1:0]  in_imm,
  input  logic [ADDR_W-1:0] in_pc,
  input  logic [ROB_W-1:0]  in_robpos,
  input  logic [DATA_W-1:0] in_vj,
  input  logic [DATA_W-1:0] in_vk,
  output logic              out_flag,
  output logic [DATA_W-1:0] out_val,
  output logic [ROB_W-1:0]  out_robpos,
  output logic              out_jump,
  output logic [ADDR_W-1:0] out_target
);

  logic [DATA_W-1:0] core_val;
  logic              core_jump;
  logic [ADDR_W-1:0] core_target;

  alu_core u_core (
    .op     (in_op),
    .imm    (in_imm),
    .pc     (in_pc),
    .vj     (in_vj),
    .vk     (in_vk),
    .val    (core_val),
    .jump   (core_jump),
    .target (core_target)
  );

  // ready low freezes everything, including the valid pulse; data is only reloaded on a live issue.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_flag   <= 1'b0;
      out_val    <= '0;
      out_robpos <= '0;
      out_jump   <= 1'b0;
      out_target <= '0;
    end else if (ready) begin
      if (flush) begin
        out_flag <= 1'b0;
      end else if (in_flag) begin
        out_flag   <= 1'b1;
        out_val    <= core_val;
        out_robpos <= in_robpos;
        out_jump   <= core_jump;
        out_target <= core_target;
      end else begin
        out_flag <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_unit.sv
// Self-checking bench for alu_unit: directed corner cases plus randomized traffic against a reference model.
module tb_alu_unit;
  import alu_unit_pkg::*;

  logic        clk;
  logic        reset;
  logic        ready;
  logic        flush;
  logic        in_flag;
  logic [5:0]  in_op;
  logic [31:0] in_imm;
  logic [31:0] in_pc;
  logic [3:0]  in_robpos;
  logic [31:0] in_vj;
  logic [31:0] in_vk;
  logic        out_flag;
  logic [31:0] out_val;
  logic [3:0]  out_robpos;
  logic        out_jump;
  logic [31:0] out_target;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [5:0]  op;
    logic [31:0] imm;
    logic [31:0] pc;
    logic [31:0] vj;
    logic [31:0] vk;
    logic [31:0] val;
    logic        jump;
    logic [31:0] tgt;
  } vec_t;

  alu_unit dut (
    .clk        (clk),
    .reset      (reset),
    .ready      (ready),
    .flush      (flush),
    .in_flag    (in_flag),
    .in_op      (in_op),
    .in_imm     (in_imm),
    .in_pc      (in_pc),
    .in_robpos  (in_robpos),
    .in_vj      (in_vj),
    .in_vk      (in_vk),
    .out_flag   (out_flag),
    .out_val    (out_val),
    .out_robpos (out_robpos),
    .out_jump   (out_jump),
    .out_target (out_target)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference semantics written with plain integer arithmetic.
  function automatic void ref_model(input logic [5:0] op, input logic [31:0] imm, pc, vj, vk,
                                    output logic [31:0] val, output logic jump, output logic [31:0] tgt);
    int signed sj, sk, si;
    longint unsigned uj, uk, ui;
    logic cond;
    sj = vj; sk = vk; si = imm;
    uj = {32'd0, vj}; uk = {32'd0, vk}; ui = {32'd0, imm};
    val = 32'd0; jump = 1'b0; tgt = pc + 32'd4; cond = 1'b0;
    case (op)
      6'd1:  val = imm;
      6'd2:  val = pc + imm;
      6'd3:  begin val = pc + 32'd4; jump = 1'b1; tgt = pc + imm; end
      6'd4:  begin val = pc + 32'd4; jump = 1'b1; tgt = ((vj + imm) / 2) * 2; end
      6'd11: val = 32'(sj + si);
      6'd12: val = (sj < si) ? 32'd1 : 32'd0;
      6'd13: val = (uj < ui) ? 32'd1 : 32'd0;
      6'd14: val = vj ^ imm;
      6'd15: val = vj | imm;
      6'd16: val = vj & imm;
      6'd17: val = 32'(uj * (64'd1 << (imm % 32)));
      6'd18: val = 32'(uj / (64'd1 << (imm % 32)));
      6'd19: val = 32'(sj >>> (imm % 32));
      6'd20: val = 32'(uj + uk);
      6'd21: val = 32'(uj - uk);
      6'd22: val = 32'(uj * (64'd1 << (vk % 32)));
      6'd23: val = (sj < sk) ? 32'd1 : 32'd0;
      6'd24: val = (uj < uk) ? 32'd1 : 32'd0;
      6'd25: val = vj ^ vk;
      6'd26: val = vj | vk;
      6'd27: val = vj & vk;
      6'd28: val = 32'(uj / (64'd1 << (vk % 32)));
      6'd29: val = 32'(sj >>> (vk % 32));
      default: ;
    endcase
    if (op >= 6'd5 && op <= 6'd10) begin
      case (op)
        6'd5:    cond = (uj == uk);
        6'd6:    cond = (uj != uk);
        6'd7:    cond = (sj < sk);
        6'd8:    cond = !(sj < sk);
        6'd9:    cond = (uj < uk);
        default: cond = !(uj < uk);
      endcase
      jump = cond;
      tgt  = cond ? pc + imm : pc + 32'd4;
    end
  endfunction

  task automatic drive(input logic f, input logic [5:0] op, input logic [31:0] imm, pc, vj, vk,
                       input logic [3:0] rob);
    in_flag = f; in_op = op; in_imm = imm; in_pc = pc;
    in_vj = vj; in_vk = vk; in_robpos = rob;
  endtask

  task automatic test_reset();
    drive(1'b1, OP_ADD, 32'd0, 32'h40, 32'd7, 32'd9, 4'd3);
    ready = 1'b1; flush = 1'b0;
    @(posedge clk); @(negedge clk);
    #2 reset = 1'b1;
    #1;
    checks++;
    if (out_flag !== 1'b0 || out_val !== 32'd0 || out_robpos !== 4'd0 ||
        out_jump !== 1'b0 || out_target !== 32'd0) begin
      errors++;
      $display("[TB] FAIL reset_async: got flag=%b val=%h rob=%h jump=%b tgt=%h expected all zero",
               out_flag, out_val, out_robpos, out_jump, out_target);
    end
    @(negedge clk);
    in_flag = 1'b0;
    reset = 1'b0;
    @(posedge clk); @(negedge clk);
    checks++;
    if (out_flag !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_idle_flag: got %b expected 0", out_flag);
    end
  endtask

  task automatic test_directed();
    vec_t v[12];
    v[0]  = '{OP_ADD,   32'd0,        32'h40,  32'hFFFFFFFF, 32'd1,        32'd0,        1'b0, 32'h44};
    v[1]  = '{OP_SUB,   32'd0,        32'h40,  32'd0,        32'd1,        32'hFFFFFFFF, 1'b0, 32'h44};
    v[2]  = '{OP_SRA,   32'd0,        32'h40,  32'h80000000, 32'h3F,       32'hFFFFFFFF, 1'b0, 32'h44};
    v[3]  = '{OP_SLTU,  32'd0,        32'h40,  32'd1,        32'hFFFFFFFF, 32'd1,        1'b0, 32'h44};
    v[4]  = '{OP_SLT,   32'd0,        32'h40,  32'd1,        32'hFFFFFFFF, 32'd0,        1'b0, 32'h44};
    v[5]  = '{OP_BLT,   32'h20,       32'h100, 32'hFFFFFFFF, 32'd0,        32'd0,        1'b1, 32'h120};
    v[6]  = '{OP_BLTU,  32'h20,       32'h100, 32'hFFFFFFFF, 32'd0,        32'd0,        1'b0, 32'h104};
    v[7]  = '{OP_JALR,  32'd0,        32'h100, 32'h203,      32'd0,        32'h104,      1'b1, 32'h202};
    v[8]  = '{OP_SLTIU, 32'hFFFFFFFF, 32'h40,  32'd5,        32'd0,        32'd1,        1'b0, 32'h44};
    v[9]  = '{OP_LUI,   32'h12345000, 32'h40,  32'd0,        32'd0,        32'h12345000, 1'b0, 32'h44};
    v[10] = '{6'd63,    32'h10,       32'h200, 32'd3,        32'd4,        32'd0,        1'b0, 32'h204};
    v[11] = '{OP_JAL,   32'hFFFFFFF0, 32'h100, 32'd0,        32'd0,        32'h104,      1'b1, 32'hF0};
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, v[i].op, v[i].imm, v[i].pc, v[i].vj, v[i].vk, 4'(i));
      @(posedge clk); @(negedge clk);
      in_flag = 1'b0;
      checks++;
      if (out_flag !== 1'b1 || out_robpos !== 4'(i)) begin
        errors++;
        $display("[TB] FAIL dir%0d_flag: got flag=%b rob=%h expected flag=1 rob=%h", i, out_flag, out_robpos, 4'(i));
      end
      checks++;
      if (out_val !== v[i].val) begin
        errors++;
        $display("[TB] FAIL dir%0d_val: got %h expected %h", i, out_val, v[i].val);
      end
      checks++;
      if (out_jump !== v[i].jump || out_target !== v[i].tgt) begin
        errors++;
        $display("[TB] FAIL dir%0d_branch: got jump=%b tgt=%h expected jump=%b tgt=%h",
                 i, out_jump, out_target, v[i].jump, v[i].tgt);
      end
      @(posedge clk); @(negedge clk);
      checks++;
      if (out_flag !== 1'b0) begin
        errors++;
        $display("[TB] FAIL dir%0d_pulse: got flag=%b expected 0", i, out_flag);
      end
    end
  endtask

  task automatic test_stall();
    drive(1'b1, OP_ADDI, 32'd10, 32'h80, 32'd32, 32'd0, 4'd5);
    @(posedge clk); @(negedge clk);
    ready = 1'b0;
    drive(1'b1, OP_SUB, 32'd0, 32'h90, 32'd1, 32'd2, 4'd9);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); @(negedge clk);
      checks++;
      if (out_flag !== 1'b1 || out_robpos !== 4'd5 || out_val !== 32'd42) begin
        errors++;
        $display("[TB] FAIL stall_hold%0d: got flag=%b rob=%h val=%h expected flag=1 rob=5 val=0000002a",
                 i, out_flag, out_robpos, out_val);
      end
    end
    in_flag = 1'b0;
    ready = 1'b1;
    @(posedge clk); @(negedge clk);
    checks++;
    if (out_flag !== 1'b0) begin
      errors++;
      $display("[TB] FAIL stall_release: got flag=%b expected 0", out_flag);
    end
  endtask

  task automatic test_flush();
    drive(1'b1, OP_XOR, 32'd0, 32'h300, 32'hF0F0, 32'h0FF0, 4'd6);
    @(posedge clk); @(negedge clk);
    checks++;
    if (out_flag !== 1'b1 || out_val !== 32'hFF00) begin
      errors++;
      $display("[TB] FAIL flush_prev: got flag=%b val=%h expected flag=1 val=0000ff00", out_flag, out_val);
    end
    drive(1'b1, OP_ADD, 32'd0, 32'h304, 32'd1, 32'd1, 4'd7);
    flush = 1'b1;
    @(posedge clk); @(negedge clk);
    flush = 1'b0;
    checks++;
    if (out_flag !== 1'b0) begin
      errors++;
      $display("[TB] FAIL flush_kill: got flag=%b expected 0", out_flag);
    end
    drive(1'b1, OP_OR, 32'd0, 32'h308, 32'h100, 32'h001, 4'd8);
    @(posedge clk); @(negedge clk);
    in_flag = 1'b0;
    checks++;
    if (out_flag !== 1'b1 || out_robpos !== 4'd8 || out_val !== 32'h101 || out_target !== 32'h30C) begin
      errors++;
      $display("[TB] FAIL flush_after: got flag=%b rob=%h val=%h tgt=%h expected 1/8/00000101/0000030c",
               out_flag, out_robpos, out_val, out_target);
    end
    @(posedge clk); @(negedge clk);
  endtask

  task automatic test_reset_mid();
    drive(1'b1, OP_AND, 32'd0, 32'h400, 32'hFF, 32'h0F, 4'd2);
    @(posedge clk); #2 reset = 1'b1;
    #1;
    checks++;
    if (out_flag !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_mid: got flag=%b expected 0", out_flag);
    end
    @(negedge clk);
    reset = 1'b0;
    drive(1'b1, OP_AUIPC, 32'h1000, 32'h400, 32'd0, 32'd0, 4'd4);
    @(posedge clk); @(negedge clk);
    in_flag = 1'b0;
    checks++;
    if (out_flag !== 1'b1 || out_val !== 32'h1400 || out_robpos !== 4'd4) begin
      errors++;
      $display("[TB] FAIL reset_mid_next: got flag=%b val=%h rob=%h expected 1/00001400/4",
               out_flag, out_val, out_robpos);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] ev;
    logic ej;
    logic [31:0] et;
    logic [31:0] vjs[4];
    for (int i = 0; i < 4; i++) vjs[i] = $urandom;
    drive(1'b1, OP_ADDI, 32'd100, 32'h500, vjs[0], 32'd0, 4'd0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); @(negedge clk);
      if (i < 3) drive(1'b1, OP_ADDI, 32'd100, 32'h500 + 32'(4 * (i + 1)), vjs[i + 1], 32'd0, 4'(i + 1));
      else in_flag = 1'b0;
      ref_model(OP_ADDI, 32'd100, 32'h500 + 32'(4 * i), vjs[i], 32'd0, ev, ej, et);
      checks++;
      if (out_flag !== 1'b1 || out_robpos !== 4'(i) || out_val !== ev) begin
        errors++;
        $display("[TB] FAIL b2b%0d: got flag=%b rob=%h val=%h expected 1/%h/%h",
                 i, out_flag, out_robpos, out_val, 4'(i), ev);
      end
    end
    @(posedge clk); @(negedge clk);
    checks++;
    if (out_flag !== 1'b0) begin
      errors++;
      $display("[TB] FAIL b2b_end: got flag=%b expected 0", out_flag);
    end
  endtask

  task automatic test_random();
    logic [31:0] ev, et;
    logic ej;
    logic [5:0] op;
    logic [31:0] imm, pc, vj, vk;
    logic [3:0] rob;
    logic f;
    for (int n = 0; n < 300; n++) begin
      f   = ($urandom_range(0, 4) != 0);
      op  = 6'($urandom_range(0, 33));
      imm = ($urandom_range(0, 1) == 0) ? 32'($signed(12'($urandom))) : $urandom;
      pc  = {$urandom} & 32'hFFFFFFFC;
      vj  = $urandom;
      vk  = ($urandom_range(0, 3) == 0) ? vj : $urandom;
      rob = 4'($urandom);
      drive(f, op, imm, pc, vj, vk, rob);
      @(posedge clk); @(negedge clk);
      checks++;
      if (out_flag !== f) begin
        errors++;
        $display("[TB] FAIL rand%0d_flag: got %b expected %b", n, out_flag, f);
      end
      if (f) begin
        ref_model(op, imm, pc, vj, vk, ev, ej, et);
        checks++;
        if (out_val !== ev || out_jump !== ej || out_target !== et || out_robpos !== rob) begin
          errors++;
          $display("[TB] FAIL rand%0d op=%0d: got val=%h jump=%b tgt=%h rob=%h expected %h/%b/%h/%h",
                   n, op, out_val, out_jump, out_target, out_robpos, ev, ej, et, rob);
        end
      end
    end
    in_flag = 1'b0;
  endtask

  initial begin
    reset = 1'b1; ready = 1'b1; flush = 1'b0;
    drive(1'b0, 6'd0, 32'd0, 32'd0, 32'd0, 32'd0, 4'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    test_reset();
    test_directed();
    test_stall();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
